// File: rtl/cache_bus_arbiter.sv
// 2:1 arbiter sharing one sram-like memory bus between the I-cache and D-cache miss ports.
// Define CACHE_ARB_RR_EN for round-robin arbitration; the default build uses fixed data-over-inst priority.
module cache_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic                  inst_wr,
  input  logic [1:0]            inst_size,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic [DATA_WIDTH-1:0] inst_wdata,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [1:0]            mem_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state;
  logic   gnt;
  logic   last_gnt;
  logic   pick;
  logic   busy;
  logic   addr_hs;
  logic   done;
  logic   route_rdata;

  // Winner of the IDLE arbitration; 1 selects the data cache.
  always_comb begin
    pick = last_gnt;
`ifdef CACHE_ARB_RR_EN
    if (data_req && inst_req)
      pick = ~last_gnt;
    else if (data_req || inst_req)
      pick = data_req;
`else
    if (data_req)
      pick = 1'b1;
    else if (inst_req)
      pick = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_req || inst_req) begin
            gnt   <= pick;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (mem_addr_ok && mem_data_ok) begin
            last_gnt <= gnt;
            state    <= IDLE;
          end else if (mem_addr_ok) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (mem_data_ok) begin
            last_gnt <= gnt;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus payload follows the grant while a transaction is open and is zero when idle.
  always_comb begin
    busy      = (state != IDLE);
    mem_req   = (state == ADDR);
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (busy) begin
      mem_wr    = gnt ? data_wr    : inst_wr;
      mem_size  = gnt ? data_size  : inst_size;
      mem_addr  = gnt ? data_addr  : inst_addr;
      mem_wdata = gnt ? data_wdata : inst_wdata;
    end
  end

  // Handshakes pass straight through to the granted cache only; the other side stays zero.
  always_comb begin
    addr_hs      = (state == ADDR) && mem_addr_ok;
    done         = ((state == ADDR) && mem_addr_ok && mem_data_ok) ||
                   ((state == DATA) && mem_data_ok);
    route_rdata  = (state == DATA) || done;
    inst_addr_ok = addr_hs && !gnt;
    data_addr_ok = addr_hs && gnt;
    inst_data_ok = done && !gnt;
    data_data_ok = done && gnt;
    inst_rdata   = (route_rdata && !gnt) ? mem_rdata : '0;
    data_rdata   = (route_rdata && gnt)  ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Scoreboard bench for cache_bus_arbiter: stimulus pushes expected bus/handshake events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_cache_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int K_REQ = 0;
  localparam int K_AOK = 1;
  localparam int K_DOK = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, inst_wr, data_req, data_wr;
  logic [1:0]    inst_size, data_size, mem_size;
  logic [AW-1:0] inst_addr, data_addr, mem_addr;
  logic [DW-1:0] inst_wdata, data_wdata, mem_wdata;
  logic [DW-1:0] inst_rdata, data_rdata, mem_rdata;
  logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok;

  typedef struct {
    int          kind;
    int          src;
    int          cyc;
    logic        req;
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_req = 1'b0;

  cache_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int kind, input int src, input logic req, input logic [31:0] addr,
                          input logic wr, input logic [1:0] size, input logic [31:0] wdata,
                          input logic [31:0] rdata);
    exp_t e;
    e.kind = kind; e.src = src; e.cyc = cyc; e.req = req; e.addr = addr;
    e.wr = wr; e.size = size; e.wdata = wdata; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Pops the oldest expectation and compares it against what the DUT shows this cycle.
  task automatic check_event(input int kind, input int src);
    exp_t        e;
    logic [31:0] rd, other_rd;
    logic        bad;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_event kind=%0d src=%0d cyc=%0d", kind, src, cyc);
      return;
    end
    e = exp_q.pop_front();
    rd       = (src == 1) ? data_rdata : inst_rdata;
    other_rd = (src == 1) ? inst_rdata : data_rdata;
    bad = (e.kind != kind) || (e.src != src) || (e.cyc != cyc) || (mem_req !== e.req) ||
          (mem_addr !== e.addr) || (mem_wr !== e.wr) || (mem_size !== e.size) ||
          (mem_wdata !== e.wdata);
    if (kind == K_DOK)
      bad = bad || (rd !== e.rdata) || (other_rd !== 32'h0);
    if (bad) begin
      errors++;
      $display("[TB] FAIL event: got kind=%0d src=%0d cyc=%0d req=%b addr=%h wr=%b size=%b wdata=%h rdata=%h other_rdata=%h; required kind=%0d src=%0d cyc=%0d req=%b addr=%h wr=%b size=%b wdata=%h rdata=%h",
               kind, src, cyc, mem_req, mem_addr, mem_wr, mem_size, mem_wdata, rd, other_rd,
               e.kind, e.src, e.cyc, e.req, e.addr, e.wr, e.size, e.wdata, e.rdata);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && !prev_req) check_event(K_REQ, 0);
      if (inst_addr_ok) check_event(K_AOK, 0);
      if (data_addr_ok) check_event(K_AOK, 1);
      if (inst_data_ok) check_event(K_DOK, 0);
      if (data_data_ok) check_event(K_DOK, 1);
    end
    prev_req = mem_req;
  end

  task automatic set_req(input int src, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (src == 1) begin
      data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
    end else begin
      inst_req = 1'b1; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wdata;
    end
  endtask

  task automatic drop_req(input int src);
    if (src == 1) data_req = 1'b0;
    else inst_req = 1'b0;
  endtask

  // Called in the first ADDR cycle; plays the bus side and records the expected events.
  task automatic apply_stimulus(input int src, input int addr_wait, input int data_wait,
                                input logic [31:0] rd, input logic [31:0] ea, input logic ew,
                                input logic [1:0] es, input logic [31:0] ewd);
    push_exp(K_REQ, 0, 1'b1, ea, ew, es, ewd, 32'h0);
    repeat (addr_wait) step();
    mem_addr_ok = 1'b1;
    push_exp(K_AOK, src, 1'b1, ea, ew, es, ewd, 32'h0);
    if (data_wait == 0) begin
      mem_data_ok = 1'b1;
      mem_rdata   = rd;
      push_exp(K_DOK, src, 1'b1, ea, ew, es, ewd, rd);
      step();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
      drop_req(src);
    end else begin
      step();
      mem_addr_ok = 1'b0;
      drop_req(src);
      repeat (data_wait - 1) step();
      mem_data_ok = 1'b1;
      mem_rdata   = rd;
      push_exp(K_DOK, src, 1'b0, ea, ew, es, ewd, rd);
      step();
      mem_data_ok = 1'b0; mem_rdata = '0;
    end
  endtask

  task automatic check_all_zero(input string name);
    @(negedge clk);
    check_output({name, "_payload"}, {mem_addr, mem_wdata}, 64'h0);
    check_output({name, "_ctrl"},
                 {52'h0, mem_req, mem_wr, mem_size, inst_addr_ok, inst_data_ok, data_addr_ok,
                  data_data_ok, |inst_rdata, |data_rdata}, 64'h0);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("idle");

    // Single I-cache read: addr_ok 3 cycles after req, data_ok 5 cycles after.
    set_req(0, 1'b0, 2'b10, 32'hBFC00000, 32'h0);
    step();
    apply_stimulus(0, 2, 2, 32'h3C1D0000, 32'hBFC00000, 1'b0, 2'b10, 32'h0);
    step();

    // Simultaneous requests: data wins, one idle cycle, then inst.
    set_req(1, 1'b0, 2'b10, 32'h80001000, 32'h0);
    set_req(0, 1'b0, 2'b10, 32'hBFC00004, 32'h0);
    step();
    apply_stimulus(1, 1, 1, 32'h11112222, 32'h80001000, 1'b0, 2'b10, 32'h0);
    step();
    apply_stimulus(0, 1, 2, 32'h33334444, 32'hBFC00004, 1'b0, 2'b10, 32'h0);
    step();

    // Data-only transaction leaves last_gnt=1, then both request again.
    set_req(1, 1'b0, 2'b10, 32'h80002000, 32'h0);
    step();
    apply_stimulus(1, 0, 1, 32'h55556666, 32'h80002000, 1'b0, 2'b10, 32'h0);
    set_req(1, 1'b0, 2'b01, 32'h80003000, 32'h0);
    set_req(0, 1'b0, 2'b10, 32'hBFC00008, 32'h0);
    step();
`ifdef CACHE_ARB_RR_EN
    apply_stimulus(0, 1, 1, 32'h77778888, 32'hBFC00008, 1'b0, 2'b10, 32'h0);
    step();
    apply_stimulus(1, 1, 1, 32'h9999AAAA, 32'h80003000, 1'b0, 2'b01, 32'h0);
`else
    apply_stimulus(1, 1, 1, 32'h9999AAAA, 32'h80003000, 1'b0, 2'b01, 32'h0);
    step();
    apply_stimulus(0, 1, 1, 32'h77778888, 32'hBFC00008, 1'b0, 2'b10, 32'h0);
`endif
    step();

    // D-cache write with a slow addr_ok.
    set_req(1, 1'b1, 2'b10, 32'h80004000, 32'hDEADBEEF);
    step();
    apply_stimulus(1, 3, 1, 32'h0, 32'h80004000, 1'b1, 2'b10, 32'hDEADBEEF);
    step();

    // addr_ok and data_ok together; the following stray data_ok must be ignored.
    set_req(0, 1'b0, 2'b10, 32'hBFC00010, 32'h0);
    step();
    apply_stimulus(0, 1, 0, 32'hA5A5A5A5, 32'hBFC00010, 1'b0, 2'b10, 32'h0);
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hFFFF0000;
    @(negedge clk);
    check_output("idle_after_same_cycle_ok", {63'h0, mem_req}, 64'h0);
    step();
    mem_data_ok = 1'b0; mem_rdata = '0;
    step();

    // Reset while in DATA discards the transaction.
    set_req(0, 1'b0, 2'b10, 32'hBFC00020, 32'h0);
    step();
    push_exp(K_REQ, 0, 1'b1, 32'hBFC00020, 1'b0, 2'b10, 32'h0, 32'h0);
    mem_addr_ok = 1'b1;
    push_exp(K_AOK, 0, 1'b1, 32'hBFC00020, 1'b0, 2'b10, 32'h0, 32'h0);
    step();
    mem_addr_ok = 1'b0;
    inst_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_data_ok = 1'b1;
    mem_addr_ok = 1'b1;
    mem_rdata   = 32'h12345678;
    check_all_zero("after_mid_reset");
    step();
    mem_data_ok = 1'b0; mem_addr_ok = 1'b0; mem_rdata = '0;
    step();

    // Normal service resumes after the reset.
    set_req(1, 1'b0, 2'b00, 32'h80005000, 32'h0);
    step();
    apply_stimulus(1, 2, 1, 32'hCAFEF00D, 32'h80005000, 1'b0, 2'b00, 32'h0);
    repeat (3) step();

    check_output("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- 2:1 arbiter that shares one sram-like memory bus between the instruction-cache and data-cache miss ports.
- Sits between the caches and the downstream AXI bridge; the bus carries req/wr/size/addr/wdata/rdata/addr_ok/data_ok.
- Allows at most one transaction in flight; address/data handshakes are routed only to the granted cache.
- Default policy is fixed priority, data over instruction.

Parameters:
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, read/write data width on all ports

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- inst_req  input  1  I-cache request, held until inst_addr_ok
- inst_wr  input  1  I-cache write flag (normally 0)
- inst_size  input  2  I-cache access size
- inst_addr  input  ADDR_WIDTH  I-cache address
- inst_wdata  input  DATA_WIDTH  I-cache write data
- inst_rdata  output  DATA_WIDTH  read data to I-cache
- inst_addr_ok  output  1  I-cache address accepted
- inst_data_ok  output  1  I-cache transaction complete
- data_req, data_wr, data_size, data_addr, data_wdata  inputs  1/1/2/ADDR_WIDTH/DATA_WIDTH  D-cache request group, same semantics as the inst_* group
- data_rdata  output  DATA_WIDTH  read data to D-cache
- data_addr_ok  output  1  D-cache address accepted
- data_data_ok  output  1  D-cache transaction complete
- mem_req  output  1  bus request
- mem_wr  output  1  bus write flag
- mem_size  output  2  bus access size
- mem_addr  output  ADDR_WIDTH  bus address
- mem_wdata  output  DATA_WIDTH  bus write data
- mem_rdata  input  DATA_WIDTH  bus read data
- mem_addr_ok  input  1  bus address accepted
- mem_data_ok  input  1  bus transaction complete

Behaviour:
- State register, encoded {IDLE, ADDR, DATA}; grant register gnt (0=inst, 1=data).
- Reset:
  - state=IDLE, gnt=0, last_gnt=0.
  - All outputs are 0: mem_req, mem_wr, mem_size, mem_addr, mem_wdata, both *_addr_ok, both *_data_ok, both *_rdata.
- IDLE:
  - mem_req=0; no handshake outputs asserted.
  - If data_req or inst_req is high: latch the winner into gnt, go to ADDR.
  - Winner is data when data_req is high; otherwise inst (fixed priority).
  - If neither is high: stay in IDLE.
  - Arbitration costs exactly one cycle: the first mem_req comes 1 cycle after the winning req rises.
- ADDR:
  - mem_req=1; mem_wr/size/addr/wdata are muxed from the gnt source.
  - {gnt}_addr_ok = mem_addr_ok.
  - If mem_addr_ok and mem_data_ok are both high in the same cycle: go to IDLE and pulse {gnt}_data_ok in that same cycle.
  - Else if mem_addr_ok: go to DATA.
  - Otherwise: stay in ADDR, with mem_req held high and stable.
- DATA:
  - mem_req=0; mem_* payload still driven from gnt.
  - {gnt}_data_ok = mem_data_ok and {gnt}_rdata = mem_rdata.
  - On mem_data_ok: last_gnt<=gnt, go to IDLE.
- Outputs to the non-granted cache stay 0 at all times: rdata=0, addr_ok=0, data_ok=0.
- A mem_data_ok arriving in IDLE is ignored: no *_data_ok is asserted.
- A requester that drops req while in ADDR is a protocol violation; the arbiter does not check it.
- Back-to-back: after data_ok the state returns to IDLE, so consecutive transactions are separated by at least one IDLE cycle.
- Reset mid-transaction: state returns to IDLE and all outputs go to 0 on the next edge; the in-flight grant is discarded.
- All payload muxing is combinational from gnt; no data buffering.

Optional Feature:
- CACHE_ARB_RR_EN defined:
  - Round-robin arbitration. When both requests are high in IDLE, the grant goes to the source opposite last_gnt.
  - A single active request wins regardless of last_gnt.
- CACHE_ARB_RR_EN undefined:
  - Fixed data priority; last_gnt is still updated but unused.

Test Plan:
- inst_req=1, inst_addr=0xBFC00000; bus asserts addr_ok at cycle 3 and data_ok at cycle 5 with rdata=0x3C1D0000.
  - Required: mem_req high cycles 1-3, mem_addr=0xBFC00000, inst_addr_ok at cycle 3, inst_data_ok with inst_rdata=0x3C1D0000 at cycle 5.
  - Required: data_* handshake outputs stay 0 throughout.
- inst_req and data_req rise together, data_addr=0x80001000, inst_addr=0xBFC00004.
  - Required: first mem_addr=0x80001000; after data_data_ok, one IDLE cycle, then mem_addr=0xBFC00004.
- Repeat the previous stimulus with CACHE_ARB_RR_EN defined and last_gnt=1.
  - Required: inst is served first.
- data_req=1, data_wr=1, data_size=2'b10, data_wdata=0xDEADBEEF.
  - Required: mem_wr=1, mem_size=2'b10, mem_wdata=0xDEADBEEF while in ADDR.
- mem_addr_ok and mem_data_ok pulse in the same cycle.
  - Required: addr_ok and data_ok to the granted cache in that same cycle; state=IDLE on the next cycle.
- Assert rst while in DATA.
  - Required: next cycle mem_req=0, all *_ok=0, state=IDLE.
  - Required: a later stray mem_data_ok produces no *_data_ok.
